// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: write-back source encodings, register zero, datapath width
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;

    typedef enum logic [1:0] {
        MTR_ALU = 2'b00,
        MTR_MEM = 2'b01,
        MTR_PC4 = 2'b10,
        MTR_IRQ = 2'b11
    } mtr_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_mux.sv
// rtl/wb_regfile_mux.sv - wb_mux: 4:1 write-back source select feeding the register file and forwarding unit
module wb_mux #(
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic [1:0]        i_sel,
    input  logic [DATA_W-1:0] i_alu,
    input  logic [DATA_W-1:0] i_mem,
    input  logic [DATA_W-1:0] i_pc4,
    input  logic [DATA_W-1:0] i_irq,
    output logic [DATA_W-1:0] o_data
);
    import cpu_pkg::*;

    always_comb begin
        o_data = i_alu;
        case (i_sel)
            MTR_ALU: o_data = i_alu;
            MTR_MEM: o_data = i_mem;
            MTR_PC4: o_data = i_pc4;
            MTR_IRQ: o_data = i_irq;
            default: o_data = i_alu;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back stage and 32x32 register file; WB_BYPASS_EN selects write-first reads
module wb_regfile #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int NREGS  = cpu_pkg::NREGS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     RegWrite_wb,
    input  logic [1:0]               MemtoReg_wb,
    input  logic [$clog2(NREGS)-1:0] RegWriteAddr_wb,
    input  logic [DATA_W-1:0]        ALUResult_wb,
    input  logic [DATA_W-1:0]        MemReadData_wb,
    input  logic [DATA_W-1:0]        PC_4_wb,
    input  logic [DATA_W-1:0]        PC_IRQ_wb,
    input  logic [$clog2(NREGS)-1:0] rs_addr,
    input  logic [$clog2(NREGS)-1:0] rt_addr,
    output logic [DATA_W-1:0]        rs_data,
    output logic [DATA_W-1:0]        rt_data,
    output logic [DATA_W-1:0]        wb_data,
    output logic                     wb_we,
    output logic [31:0]              wb_count
);
    import cpu_pkg::*;

    localparam int AW = $clog2(NREGS);

    logic [DATA_W-1:0] r_regs [0:NREGS-1];
    logic [31:0]       r_wb_count;
    logic [DATA_W-1:0] w_wb_data;
    logic              w_wb_we;
    logic              w_byp_rs;
    logic              w_byp_rt;

    wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .i_sel  (MemtoReg_wb),
        .i_alu  (ALUResult_wb),
        .i_mem  (MemReadData_wb),
        .i_pc4  (PC_4_wb),
        .i_irq  (PC_IRQ_wb),
        .o_data (w_wb_data)
    );

    // Writes to r0 are not real writes: they neither commit nor count.
    assign w_wb_we = RegWrite_wb && (RegWriteAddr_wb != AW'(REG_ZERO));
    assign wb_data = w_wb_data;
    assign wb_we   = w_wb_we;

`ifdef WB_BYPASS_EN
    assign w_byp_rs = w_wb_we && (rs_addr == RegWriteAddr_wb);
    assign w_byp_rt = w_wb_we && (rt_addr == RegWriteAddr_wb);
`else
    assign w_byp_rs = 1'b0;
    assign w_byp_rt = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_we) begin
            r_regs[RegWriteAddr_wb] <= w_wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_count <= '0;
        end else if (w_wb_we) begin
            r_wb_count <= r_wb_count + 32'd1;
        end
    end

    assign wb_count = r_wb_count;

    // Reads are forced to zero while reset is high so a bypass cannot leak data.
    always_comb begin
        rs_data = '0;
        if (!reset && (rs_addr != AW'(REG_ZERO))) begin
            rs_data = w_byp_rs ? w_wb_data : r_regs[rs_addr];
        end
    end

    always_comb begin
        rt_data = '0;
        if (!reset && (rt_addr != AW'(REG_ZERO))) begin
            rt_data = w_byp_rt ? w_wb_data : r_regs[rt_addr];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile against a behavioural register-file model
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        RegWrite_wb;
    logic [1:0]  MemtoReg_wb;
    logic [4:0]  RegWriteAddr_wb;
    logic [31:0] ALUResult_wb;
    logic [31:0] MemReadData_wb;
    logic [31:0] PC_4_wb;
    logic [31:0] PC_IRQ_wb;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data;
    logic        wb_we;
    logic [31:0] wb_count;

    int total = 0;
    int bad   = 0;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    wb_regfile dut (
        .clk             (clk),
        .reset           (reset),
        .RegWrite_wb     (RegWrite_wb),
        .MemtoReg_wb     (MemtoReg_wb),
        .RegWriteAddr_wb (RegWriteAddr_wb),
        .ALUResult_wb    (ALUResult_wb),
        .MemReadData_wb  (MemReadData_wb),
        .PC_4_wb         (PC_4_wb),
        .PC_IRQ_wb       (PC_IRQ_wb),
        .rs_addr         (rs_addr),
        .rt_addr         (rt_addr),
        .rs_data         (rs_data),
        .rt_data         (rt_data),
        .wb_data         (wb_data),
        .wb_we           (wb_we),
        .wb_count        (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_wb();
        logic [31:0] src [4];
        src[0] = ALUResult_wb;
        src[1] = MemReadData_wb;
        src[2] = PC_4_wb;
        src[3] = PC_IRQ_wb;
        return src[MemtoReg_wb];
    endfunction

    function automatic logic m_we();
        return RegWrite_wb && (RegWriteAddr_wb != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (reset || a == 5'd0) return 32'h0;
        if (BYP && m_we() && a == RegWriteAddr_wb) return m_wb();
        return m_regs[a];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_cnt = 32'h0;
    endtask

    task automatic apply(input logic we, input logic [1:0] mtr, input logic [4:0] wa,
                         input logic [31:0] val, input logic [4:0] ra, input logic [4:0] rb);
        RegWrite_wb     = we;
        MemtoReg_wb     = mtr;
        RegWriteAddr_wb = wa;
        ALUResult_wb    = (mtr == 2'd0) ? val : 32'h0BAD_0000;
        MemReadData_wb  = (mtr == 2'd1) ? val : 32'h0BAD_0001;
        PC_4_wb         = (mtr == 2'd2) ? val : 32'h0BAD_0002;
        PC_IRQ_wb       = (mtr == 2'd3) ? val : 32'h0BAD_0003;
        rs_addr         = ra;
        rt_addr         = rb;
    endtask

    task automatic check_comb(input string tag);
        #1;
        chk({tag, ".wb_data"}, wb_data, m_wb());
        chk({tag, ".wb_we"}, {31'h0, wb_we}, {31'h0, m_we()});
        chk({tag, ".rs"}, rs_data, m_read(rs_addr));
        chk({tag, ".rt"}, rt_data, m_read(rt_addr));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (!reset && m_we()) begin
            m_regs[RegWriteAddr_wb] = m_wb();
            m_cnt = m_cnt + 32'd1;
        end
        @(negedge clk);
        chk({tag, ".count"}, wb_count, m_cnt);
    endtask

    initial begin
        reset = 1'b1;
        m_clear();
        apply(1'b0, 2'd0, 5'd0, 32'h0, 5'd0, 5'd0);
        #1;
        chk("rst.count", wb_count, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            apply(1'b0, 2'd0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            check_comb("rdzero");
            chk("rdzero.rs_const", rs_data, 32'h0);
            tick("rdzero");
        end

        apply(1'b1, 2'd1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        check_comb("wr5");
        tick("wr5");
        apply(1'b0, 2'd0, 5'd0, 32'h0, 5'd5, 5'd5);
        check_comb("rd5");
        chk("rd5.const", rs_data, 32'hDEADBEEF);
        chk("rd5.cnt_const", wb_count, 32'd1);

        apply(1'b1, 2'd0, 5'd0, 32'h12345678, 5'd0, 5'd0);
        check_comb("wr0");
        chk("wr0.we_const", {31'h0, wb_we}, 32'h0);
        tick("wr0");
        chk("wr0.rs_const", rs_data, 32'h0);
        chk("wr0.cnt_const", wb_count, 32'd1);

        apply(1'b1, 2'd0, 5'd9, 32'h11111111, 5'd0, 5'd0);
        check_comb("pre9");
        tick("pre9");
        apply(1'b1, 2'd2, 5'd9, 32'hCAFE0001, 5'd9, 5'd9);
        check_comb("byp9");
        chk("byp9.rs_const", rs_data, BYP ? 32'hCAFE0001 : 32'h11111111);
        chk("byp9.rt_const", rt_data, BYP ? 32'hCAFE0001 : 32'h11111111);
        tick("byp9");
        apply(1'b0, 2'd0, 5'd0, 32'h0, 5'd9, 5'd9);
        check_comb("aft9");
        chk("aft9.const", rt_data, 32'hCAFE0001);

        apply(1'b1, 2'd3, 5'd26, 32'h80000004, 5'd0, 5'd0);
        check_comb("irq26");
        chk("irq26.wb_const", wb_data, 32'h80000004);
        tick("irq26");
        apply(1'b1, 2'd0, 5'd3, 32'h33333333, 5'd26, 5'd3);
        check_comb("pre_rst");
        chk("pre_rst.r26", rs_data, 32'h80000004);
        reset = 1'b1;
        m_clear();
        check_comb("rst_async");
        chk("rst_async.r26", rs_data, 32'h0);
        chk("rst_async.count", wb_count, 32'h0);
        tick("rst_drop");
        reset = 1'b0;
        apply(1'b0, 2'd0, 5'd0, 32'h0, 5'd3, 5'd26);
        check_comb("rst_drop");
        chk("rst_drop.r3", rs_data, 32'h0);

        force dut.r_wb_count = 32'hFFFFFFFF;
        #1;
        release dut.r_wb_count;
        m_cnt = 32'hFFFFFFFF;
        chk("wrap.pre", wb_count, 32'hFFFFFFFF);
        apply(1'b1, 2'd0, 5'd7, 32'h00000077, 5'd0, 5'd0);
        check_comb("wrap");
        tick("wrap");
        chk("wrap.zero", wb_count, 32'h0);

        for (int n = 0; n < 300; n++) begin
            logic [4:0] wa;
            logic [4:0] ra;
            logic [4:0] rb;
            wa = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            apply(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), wa, $urandom(), ra, rb);
            check_comb("rnd");
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
